dac_dither_sequencer: RTL and testbench

- Drive side of the SPGD measurement loop. On each START it applies +DELTA then -DELTA around a latched BASE code on the DAC.
- Each phase is held for a settle window and then a measurement window.
- It controls the reset of the downstream ADC averager so that averaging covers only settled samples.
- It reports the active phase so the gradient logic can pair each average with its sign.

---
 rtl/dac_dither_pkg.sv | 34 +++
 rtl/dac_sat_add.sv | 24 ++
 rtl/dac_dither_sequencer.sv | 147 ++++++++++++++
 tb/tb_dac_dither_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_dither_pkg.sv
// Shared types and helpers for the SPGD dither sequencer: FSM state encoding,
// counter sizing and the saturating DAC-code adder.
package dac_dither_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_SETTLE,
    P_HOLD,
    M_SETTLE,
    M_HOLD,
    FIN
  } state_t;

  // One spare bit above the longest window so N-1 always fits.
  function automatic int cnt_width(input int settle_cyc, input int hold_cyc);
    return $clog2((settle_cyc > hold_cyc) ? settle_cyc : hold_cyc) + 1;
  endfunction

  // Unsigned base plus signed offset, clamped to [0, 2^width-1]; width <= 32.
  function automatic logic [31:0] sat_add(input logic [31:0]        base,
                                          input logic signed [33:0] offset,
                                          input int                 width);
    logic signed [33:0] sum;
    logic signed [33:0] top;
    sum = $signed({2'b00, base}) + offset;
    top = (34'sd1 <<< width) - 34'sd1;
    if (sum < 0)
      return '0;
    if (sum > top)
      return top[31:0];
    return sum[31:0];
  endfunction

endpackage

// File: rtl/dac_sat_add.sv
// Saturating DAC-code adder: result = clamp(BASE +/- DELTA). The offset is
// widened by two bits before negation so the most negative DELTA flips cleanly.
module dac_sat_add
  import dac_dither_pkg::*;
#(
  parameter int DAC_WIDTH = 12,
  parameter bit NEGATE    = 1'b0
) (
  input  logic [DAC_WIDTH-1:0] base,
  input  logic [DAC_WIDTH-1:0] offset,
  output logic [DAC_WIDTH-1:0] result
);

  logic signed [DAC_WIDTH+1:0] off_ext;

  always_comb begin
    off_ext = $signed({{2{offset[DAC_WIDTH-1]}}, offset});
    if (NEGATE)
      off_ext = -off_ext;
  end

  assign result = DAC_WIDTH'(sat_add(32'(base), 34'(off_ext), DAC_WIDTH));

endmodule

// File: rtl/dac_dither_sequencer.sv
// SPGD drive sequencer: on START applies BASE+DELTA then BASE-DELTA, each with
// a settle window (averager in reset) followed by a measurement window.
//
// state    | meaning
// IDLE     | waiting for START, DAC_OUT holds last code
// P_SETTLE | plus code applied, averager held in reset
// P_HOLD   | plus code applied, averager running, PHASE=0
// M_SETTLE | minus code applied, averager held in reset
// M_HOLD   | minus code applied, averager running, PHASE=1
// FIN      | DONE pulse, DAC_OUT back at BASE
module dac_dither_sequencer
  import dac_dither_pkg::*;
#(
  parameter int DAC_WIDTH  = 12,
  parameter int SETTLE_CYC = 16,
  parameter int HOLD_CYC   = 1024,
  parameter int RESET_CODE = 2048
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DAC_WIDTH-1:0] BASE,
  input  logic [DAC_WIDTH-1:0] DELTA,
  output logic [DAC_WIDTH-1:0] DAC_OUT,
  output logic                 AVG_RST,
  output logic                 MEAS_EN,
  output logic                 PHASE,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int CW = cnt_width(SETTLE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [DAC_WIDTH-1:0] RST_CODE = DAC_WIDTH'(RESET_CODE);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DAC_WIDTH-1:0] dac_q, dac_d;
  logic [DAC_WIDTH-1:0] base_q, base_d;
  logic [DAC_WIDTH-1:0] delta_q, delta_d;
  logic [DAC_WIDTH-1:0] plus_code, minus_code;
  logic                 cnt_zero;

  // Plus code is needed on the accept edge, so it is built from the live ports.
  dac_sat_add #(.DAC_WIDTH(DAC_WIDTH), .NEGATE(1'b0)) u_plus (
    .base   (BASE),
    .offset (DELTA),
    .result (plus_code)
  );

  dac_sat_add #(.DAC_WIDTH(DAC_WIDTH), .NEGATE(1'b1)) u_minus (
    .base   (base_q),
    .offset (delta_q),
    .result (minus_code)
  );

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dac_q   <= RST_CODE;
      base_q  <= '0;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
      base_q  <= base_d;
      delta_q <= delta_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    base_d  = base_q;
    delta_d = delta_q;
    AVG_RST = 1'b1;
    MEAS_EN = 1'b0;
    PHASE   = 1'b0;
    BUSY    = 1'b1;
    DONE    = 1'b0;
    case (state_q)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          base_d  = BASE;
          delta_d = DELTA;
          dac_d   = plus_code;
          cnt_d   = SETTLE_LD;
          state_d = P_SETTLE;
        end
      end
      P_SETTLE: begin
        if (cnt_zero) begin
          cnt_d   = HOLD_LD;
          state_d = P_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      P_HOLD: begin
        AVG_RST = 1'b0;
        MEAS_EN = 1'b1;
        if (cnt_zero) begin
          dac_d   = minus_code;
          cnt_d   = SETTLE_LD;
          state_d = M_SETTLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      M_SETTLE: begin
        PHASE = 1'b1;
        if (cnt_zero) begin
          cnt_d   = HOLD_LD;
          state_d = M_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      M_HOLD: begin
        AVG_RST = 1'b0;
        MEAS_EN = 1'b1;
        PHASE   = 1'b1;
        if (cnt_zero) begin
          dac_d   = base_q;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign DAC_OUT = dac_q;

endmodule

// File: tb/tb_dac_dither_sequencer.sv
// Directed bench for dac_dither_sequencer with SETTLE_CYC=4, HOLD_CYC=8:
// one run spans cycles t+1..t+25 after the START edge, IDLE again at t+26.
module tb_dac_dither_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [11:0] BASE = '0;
  logic [11:0] DELTA = '0;
  logic [11:0] DAC_OUT;
  logic        AVG_RST, MEAS_EN, PHASE, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] dac;
    logic        avg;
    logic        meas;
    logic        phase;
    logic        busy;
    logic        done;
  } outs_t;

  dac_dither_sequencer #(
    .DAC_WIDTH  (12),
    .SETTLE_CYC (4),
    .HOLD_CYC   (8),
    .RESET_CODE (2048)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .BASE    (BASE),
    .DELTA   (DELTA),
    .DAC_OUT (DAC_OUT),
    .AVG_RST (AVG_RST),
    .MEAS_EN (MEAS_EN),
    .PHASE   (PHASE),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  // Expected outputs in cycle t+k of a run (k = 1..26).
  function automatic outs_t model(input int k, input logic [11:0] p,
                                  input logic [11:0] m, input logic [11:0] b);
    outs_t o;
    o.dac   = (k <= 12) ? p : (k <= 24) ? m : b;
    o.meas  = (k >= 5 && k <= 12) || (k >= 17 && k <= 24);
    o.avg   = !o.meas;
    o.phase = o.meas && (k >= 17);
    o.busy  = (k <= 25);
    o.done  = (k == 25);
    return o;
  endfunction

  function automatic outs_t reset_vals();
    outs_t o;
    o.dac   = 12'h800;
    o.avg   = 1'b1;
    o.meas  = 1'b0;
    o.phase = 1'b0;
    o.busy  = 1'b0;
    o.done  = 1'b0;
    return o;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench in cycle t+1 of the new run.
  task automatic start_run(input logic [11:0] b, input logic [11:0] d);
    BASE  = b;
    DELTA = d;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    outs_t exp, obs;
    RST = 1'b1;
    repeat (3) tick();
    exp = reset_vals();
    obs = {DAC_OUT, AVG_RST, MEAS_EN, PHASE, BUSY, DONE};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_held got %h want %h", obs, exp);
    end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      obs = {DAC_OUT, AVG_RST, MEAS_EN, PHASE, BUSY, DONE};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle c%0d got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_codes();
    logic [11:0] vb [6] = '{12'h800, 12'hFF8, 12'h005, 12'h100, 12'h800, 12'h123};
    logic [11:0] vd [6] = '{12'h010, 12'h020, 12'h010, 12'h800, 12'h800, 12'h000};
    logic [11:0] vp [6] = '{12'h810, 12'hFFF, 12'h015, 12'h000, 12'h000, 12'h123};
    logic [11:0] vm [6] = '{12'h7F0, 12'hFD8, 12'h000, 12'h900, 12'hFFF, 12'h123};
    outs_t exp, obs;
    for (int v = 0; v < 6; v++) begin
      start_run(vb[v], vd[v]);
      for (int k = 1; k <= 26; k++) begin
        if (k > 1) tick();
        exp = model(k, vp[v], vm[v], vb[v]);
        obs = {DAC_OUT, AVG_RST, MEAS_EN, exp.meas ? PHASE : 1'b0, BUSY, DONE};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL codes v%0d k%0d got %h want %h", v, k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    outs_t exp, obs;
    start_run(12'h800, 12'h010);
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) tick();
      exp = model(k, 12'h810, 12'h7F0, 12'h800);
      obs = {DAC_OUT, AVG_RST, MEAS_EN, exp.meas ? PHASE : 1'b0, BUSY, DONE};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL start_ignored k%0d got %h want %h", k, obs, exp);
      end
      if (k == 10) begin
        BASE  = 12'h456;
        DELTA = 12'h0F0;
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
    end
  endtask

  task automatic test_reset_abort();
    outs_t exp, obs;
    start_run(12'h300, 12'h040);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick();
      exp = model(k, 12'h340, 12'h2C0, 12'h300);
      obs = {DAC_OUT, AVG_RST, MEAS_EN, exp.meas ? PHASE : 1'b0, BUSY, DONE};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_pre k%0d got %h want %h", k, obs, exp);
      end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp = reset_vals();
    for (int i = 0; i < 30; i++) begin
      if (i > 0) tick();
      obs = {DAC_OUT, AVG_RST, MEAS_EN, PHASE, BUSY, DONE};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_post c%0d got %h want %h", i, obs, exp);
      end
    end
    start_run(12'h300, 12'h040);
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) tick();
      exp = model(k, 12'h340, 12'h2C0, 12'h300);
      obs = {DAC_OUT, AVG_RST, MEAS_EN, exp.meas ? PHASE : 1'b0, BUSY, DONE};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_rerun k%0d got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    outs_t exp, obs;
    int    period;
    bit    found;
    start_run(12'h400, 12'h004);
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) tick();
      exp = model(k, 12'h404, 12'h3FC, 12'h400);
      obs = {DAC_OUT, AVG_RST, MEAS_EN, exp.meas ? PHASE : 1'b0, BUSY, DONE};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_first k%0d got %h want %h", k, obs, exp);
      end
    end
    // Now in the IDLE cycle right after DONE (one tick past it).
    start_run(12'h600, 12'h001);
    period = 2;
    checks++;
    if (DAC_OUT !== 12'h601 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got dac %h busy %b want dac 601 busy 1", DAC_OUT, BUSY);
    end
    found = 1'b0;
    while (period < 60 && !found) begin
      if (DONE === 1'b1) begin
        found = 1'b1;
      end else begin
        tick();
        period++;
      end
    end
    checks++;
    if (!found || period != 26) begin
      errors++;
      $display("FAIL b2b_period got %0d found %0d want 26", period, found);
    end
    checks++;
    if (DAC_OUT !== 12'h600) begin
      errors++;
      $display("FAIL b2b_fin_code got %h want 600", DAC_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_codes();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
